// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman round controller.
// Letters are ASCII; only 'A'..'Z' are playable.
package hangman_pkg;

    typedef logic [7:0] letter_t;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_CMP    = 3'd2,
        ST_RESULT = 3'd3,
        ST_WON    = 3'd4,
        ST_LOST   = 3'd5
    } round_state_t;

    localparam letter_t ASCII_A = 8'h41;
    localparam letter_t ASCII_Z = 8'h5A;

    function automatic logic is_upper(letter_t c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

    // Position of an uppercase letter in the 26-bit used bitmap.
    function automatic logic [4:0] letter_slot(letter_t c);
        return 5'(c - ASCII_A);
    endfunction

endpackage

// File: rtl/hangman_word_reg.sv
// Secret word store: one write port at the load index,
// one combinational read port at the compare index.
module hangman_word_reg
    import hangman_pkg::*;
#(
    parameter int WORD_LEN = 5,
    parameter int IDX_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  letter_t          wr_letter,
    input  logic [IDX_W-1:0] rd_idx,
    output letter_t          rd_letter
);

    letter_t word [WORD_LEN];

    // Letter storage; clear wins over a write on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORD_LEN; i++) word[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < WORD_LEN; i++) word[i] <= '0;
        end else if (wr_en) begin
            word[wr_idx] <= wr_letter;
        end
    end

    assign rd_letter = word[rd_idx];

endmodule

// File: rtl/hangman_round_ctrl.sv
// Hangman round sequencer: loads the secret word, arbitrates
// guesses, scans the word one letter per cycle, declares win/loss.
module hangman_round_ctrl
    import hangman_pkg::*;
#(
    parameter int WORD_LEN     = 5,
    parameter int MAX_MISTAKES = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_game,
    input  logic                host_valid,
    input  logic [7:0]          host_letter,
    output logic                host_ready,
    input  logic                guess_valid,
    input  logic [7:0]          guess_letter,
    output logic                guess_ready,
    output logic                result_valid,
    output logic                result_hit,
    output logic                result_dup,
    output logic                result_invalid,
    output logic [7:0]          last_guess,
    output logic [WORD_LEN-1:0] reveal_mask,
    output logic [2:0]          mistakes,
    output logic                game_won,
    output logic                game_lost
);

    localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);
    localparam logic [2:0] MAX_MIS = 3'(MAX_MISTAKES);

    round_state_t     state, state_n;
    logic [IDX_W-1:0] load_idx;
    logic [IDX_W-1:0] cmp_idx;
    logic [25:0]      used;
    logic             hit_flag;
    logic             dup_flag;
    logic             inv_flag;
    letter_t          rd_letter;
    logic             host_fire;
    logic             guess_fire;
    logic             guess_ok;
    logic             guess_seen;
    logic             match;

    assign host_fire  = (state == ST_LOAD) && host_valid && !new_game
                        && is_upper(host_letter);
    assign guess_fire = (state == ST_PLAY) && guess_valid;
    assign guess_ok   = is_upper(guess_letter);
    assign guess_seen = guess_ok && used[letter_slot(guess_letter)];
    assign match      = (rd_letter == last_guess);

    hangman_word_reg #(
        .WORD_LEN (WORD_LEN),
        .IDX_W    (IDX_W)
    ) u_word (
        .clk       (clk),
        .rst       (rst),
        .clr       (new_game),
        .wr_en     (host_fire),
        .wr_idx    (load_idx),
        .wr_letter (host_letter),
        .rd_idx    (cmp_idx),
        .rd_letter (rd_letter)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_n;
    end

    // Next-state logic; new_game overrides every transition.
    always_comb begin
        state_n = state;
        case (state)
            ST_LOAD:   if (host_fire && load_idx == LAST_IDX) state_n = ST_PLAY;
            ST_PLAY: begin
                if (guess_valid) begin
                    if (!guess_ok || guess_seen) state_n = ST_RESULT;
                    else                         state_n = ST_CMP;
                end
            end
            ST_CMP:    if (cmp_idx == LAST_IDX) state_n = ST_RESULT;
            ST_RESULT: begin
                if (&reveal_mask)             state_n = ST_WON;
                else if (mistakes == MAX_MIS) state_n = ST_LOST;
                else                          state_n = ST_PLAY;
            end
            ST_WON:    state_n = ST_WON;
            ST_LOST:   state_n = ST_LOST;
            default:   state_n = ST_LOAD;
        endcase
        if (new_game) state_n = ST_LOAD;
    end

    // Round datapath: load index, guess bookkeeping, word scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || new_game) begin
            load_idx    <= '0;
            cmp_idx     <= '0;
            used        <= '0;
            hit_flag    <= 1'b0;
            dup_flag    <= 1'b0;
            inv_flag    <= 1'b0;
            last_guess  <= '0;
            reveal_mask <= '0;
            mistakes    <= '0;
        end else begin
            if (host_fire) begin
                if (load_idx == LAST_IDX) begin
                    load_idx    <= '0;
                    reveal_mask <= '0;
                    mistakes    <= '0;
                    used        <= '0;
                end else begin
                    load_idx <= load_idx + IDX_W'(1);
                end
            end
            if (guess_fire) begin
                hit_flag <= 1'b0;
                dup_flag <= guess_seen;
                inv_flag <= !guess_ok;
                if (guess_ok && !guess_seen) begin
                    last_guess                     <= guess_letter;
                    used[letter_slot(guess_letter)] <= 1'b1;
                    cmp_idx                        <= '0;
                end
            end
            if (state == ST_CMP) begin
                if (match) begin
                    reveal_mask[cmp_idx] <= 1'b1;
                    hit_flag             <= 1'b1;
                end
                if (cmp_idx == LAST_IDX) begin
                    cmp_idx <= '0;
                    if (!hit_flag && !match && mistakes != 3'd7)
                        mistakes <= mistakes + 3'd1;
                end else begin
                    cmp_idx <= cmp_idx + IDX_W'(1);
                end
            end
        end
    end

    assign host_ready     = (state == ST_LOAD);
    assign guess_ready    = (state == ST_PLAY);
    assign result_valid   = (state == ST_RESULT);
    assign result_hit     = result_valid && hit_flag;
    assign result_dup     = result_valid && dup_flag;
    assign result_invalid = result_valid && inv_flag;
    assign game_won       = (state == ST_WON);
    assign game_lost      = (state == ST_LOST);

endmodule

// File: doc/hangman_round_ctrl.md
Name: hangman_round_ctrl

Overview:
Round sequencer for the wireless hangman game.
- Loads the host's secret word one letter at a time, then arbitrates player guesses.
- Rejects invalid or repeated guesses and compares each accepted guess against the word, one letter per cycle.
- Maintains the reveal mask and mistake count, and declares win or loss.
- Sits between the UART/keypad receive path and the LCD/LED status drivers.

Parameters:
WORD_LEN, 5, number of letters in the secret word; letter 0 is the first letter entered.
MAX_MISTAKES, 6, wrong guesses that end the round as lost (1..7).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
new_game  in  1  one-cycle pulse; abandon the current round and return to LOAD
host_valid  in  1  host letter strobe
host_letter  in  8  host letter, ASCII
host_ready  out  1  controller accepts host letters (LOAD state)
guess_valid  in  1  player guess strobe
guess_letter  in  8  player guess, ASCII
guess_ready  out  1  controller accepts a guess (PLAY state)
result_valid  out  1  one-cycle pulse; guess outcome is valid
result_hit  out  1  guess matched at least one letter (qualified by result_valid)
result_dup  out  1  guess was already used
result_invalid  out  1  guess was outside 'A'..'Z'
last_guess  out  8  most recently accepted guess
reveal_mask  out  WORD_LEN  bit i set = letter i revealed
mistakes  out  3  wrong-guess count
game_won  out  1  high while in WON
game_lost  out  1  high while in LOST

Behaviour:
- Reset values:
  - State LOAD.
  - All outputs 0 except host_ready=1.
  - Word, used-letter bitmap (26 bits), load index, and compare index cleared.
- States: LOAD, PLAY, CMP, RESULT, WON, LOST.
- Handshakes:
  - Transfer occurs on a clock edge with valid && ready.
  - Valid held with ready low is ignored, not queued.
- LOAD: host_ready=1.
  - A host letter in 0x41..0x5A is stored at the load index, and the index increments.
  - A letter outside that range is consumed and dropped; the index does not advance.
  - On the WORD_LEN-th stored letter, go to PLAY. On that edge, clear reveal_mask, mistakes and the used bitmap.
- PLAY: guess_ready=1.
  - Guess outside 'A'..'Z' (lowercase included): go to RESULT with invalid=1.
  - Guess whose used bit is set: go to RESULT with dup=1.
  - Otherwise: latch last_guess, set its used bit, clear the hit flag, set compare index 0, go to CMP.
- CMP: one word letter per cycle, index 0..WORD_LEN-1.
  - On a match, set reveal_mask[index] and the hit flag.
  - After index WORD_LEN-1, go to RESULT. On that same edge, if no hit, mistakes increments (saturates at 7).
- RESULT: exactly one cycle.
  - result_valid=1; hit/dup/invalid are driven from registered flags.
  - Next state, evaluated on registered values: reveal_mask all ones -> WON; else mistakes == MAX_MISTAKES -> LOST; else PLAY.
  - Dup and invalid guesses never change mistakes or reveal_mask.
- Latency from guess handshake edge to result_valid:
  - Accepted guess: WORD_LEN+1 cycles (6 by default).
  - Dup/invalid guess: 1 cycle.
- WON / LOST:
  - game_won / game_lost held high; both ready outputs 0.
  - Remain until new_game.
- new_game:
  - Highest priority in every state. Next cycle is LOAD, with word, index, mask, mistakes, bitmap and flags cleared.
  - A pending result_valid is suppressed.
  - Simultaneous host_valid is not accepted on that edge.
- Any unused state encoding returns to LOAD.
- rst asserted mid-operation: all registers return to reset values immediately (asynchronous).

Decomposition:
- Package hangman_pkg:
  - round_state_t enum
  - ASCII_A = 8'h41 and ASCII_Z = 8'h5A
  - letter_t (8-bit) typedef
- One natural sub-module: hangman_word_reg.
  - Indexed letter store: write port at the load index, read port at the compare index.
  - Clear input.

Test Plan:
- Reset, load "HELLO" (48,45,4C,4C,4F) with a 0x31 injected mid-stream -> 0x31 dropped; PLAY after the 5th valid letter; guess_ready=1, reveal_mask=00000, mistakes=0.
- Guess 'L' (4C) -> result_valid exactly 6 cycles after the handshake; hit=1; reveal_mask=5'b01100; mistakes=0.
- Guess 'L' again, then 'a' (61) -> each gives result_valid 1 cycle later, with dup=1 and invalid=1 respectively; mistakes and mask unchanged.
- Guesses Z,Q,X,J,K,W -> mistakes steps 1..6; after the 6th RESULT: LOST, game_lost=1, guess_ready=0; a further guess_valid is ignored.
- New round "HELLO", guesses H,E,L,O -> final reveal_mask=11111, game_won=1, mistakes=0.
- new_game pulsed during CMP index 2 -> next cycle LOAD, host_ready=1, mask=0, mistakes=0, no result_valid.
- rst pulsed mid-CMP -> immediate clear of all outputs.
